// File: rtl/sr_cmd_driver.sv
// SR flip-flop command driver: queues target bits and emits 00/01/10 commands that move a
// modelled flip-flop to each target. Define SR_CMD_STATS_EN to add saturating command counters.
module sr_cmd_driver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_bit,
  output logic                   in_ready,
  output logic [1:0]             sr,
  output logic                   q_model,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef SR_CMD_STATS_EN
  ,
  output logic [15:0]            set_cnt,
  output logic [15:0]            rst_cnt,
  output logic [15:0]            hold_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [3:0]    GapC   = 4'(GAP);

  typedef enum logic [1:0] {StInit, StIdle, StDrive, StGapWait} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sr_q, sr_d;
  logic            q_q, q_d;
  logic [3:0]      gap_q, gap_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            mem_q [DEPTH];
  logic            push, pop, head;

  assign in_ready   = (state_q != StInit) && (count_q < DepthC);
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];
  assign sr         = sr_q;
  assign q_model    = q_q;
  assign fifo_count = count_q;
  assign busy       = !((state_q == StIdle) && (count_q == '0));

  always_comb begin
    state_d = state_q;
    sr_d    = 2'b00;
    q_d     = q_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      StInit: begin
        // Force the external flip-flop to a known 0 before any data command.
        sr_d = 2'b01;
        q_d  = 1'b0;
        if (GAP > 0) begin
          state_d = StGapWait;
          gap_d   = GapC;
        end else begin
          state_d = StIdle;
        end
      end
      StIdle, StDrive: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          q_d     = head;
          state_d = StDrive;
          if (head && !q_q)      sr_d = 2'b10;
          else if (!head && q_q) sr_d = 2'b01;
          if ((sr_d != 2'b00) && (GAP > 0)) begin
            state_d = StGapWait;
            gap_d   = GapC;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StGapWait: begin
        gap_d = gap_q - 4'd1;
        if (gap_q <= 4'd1) begin
          gap_d   = 4'd0;
          state_d = (count_q != '0) ? StDrive : StIdle;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StInit;
      sr_q     <= 2'b00;
      q_q      <= 1'b0;
      gap_q    <= 4'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      gap_q   <= gap_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_bit;
  end

`ifdef SR_CMD_STATS_EN
  logic [15:0] set_cnt_q, rst_cnt_q, hold_cnt_q;

  // Only popped (data-driven) commands count; INIT and gap/empty holds never pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_cnt_q  <= 16'd0;
      rst_cnt_q  <= 16'd0;
      hold_cnt_q <= 16'd0;
    end else if (pop) begin
      if ((sr_d == 2'b10) && (set_cnt_q != 16'hFFFF))  set_cnt_q  <= set_cnt_q + 16'd1;
      if ((sr_d == 2'b01) && (rst_cnt_q != 16'hFFFF))  rst_cnt_q  <= rst_cnt_q + 16'd1;
      if ((sr_d == 2'b00) && (hold_cnt_q != 16'hFFFF)) hold_cnt_q <= hold_cnt_q + 16'd1;
    end
  end

  assign set_cnt  = set_cnt_q;
  assign rst_cnt  = rst_cnt_q;
  assign hold_cnt = hold_cnt_q;
`endif

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver: one instance with GAP=0 and one with GAP=3, DEPTH=4 each.
module tb_sr_cmd_driver;

  logic       clk;
  logic       rst_n;
  logic       v0, b0, rdy0, q0, busy0;
  logic [1:0] sr0;
  logic [2:0] cnt0;
  logic       v3, b3, rdy3, q3, busy3;
  logic [1:0] sr3;
  logic [2:0] cnt3;
`ifdef SR_CMD_STATS_EN
  logic [15:0] set0, rstc0, hold0, set3, rstc3, hold3;
`endif

  int errors = 0;
  int checks = 0;

  int cmds[$];
  int runs[$];
  int zrun, max_cnt, full_rdy, bad11, sent;
  bit seen, acc, last_bit;
  logic [7:0] vv, bb;

  sr_cmd_driver #(.DEPTH(4), .GAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_bit(b0), .in_ready(rdy0), .sr(sr0),
    .q_model(q0), .busy(busy0), .fifo_count(cnt0)
`ifdef SR_CMD_STATS_EN
    , .set_cnt(set0), .rst_cnt(rstc0), .hold_cnt(hold0)
`endif
  );

  sr_cmd_driver #(.DEPTH(4), .GAP(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_bit(b3), .in_ready(rdy3), .sr(sr3),
    .q_model(q3), .busy(busy3), .fifo_count(cnt3)
`ifdef SR_CMD_STATS_EN
    , .set_cnt(set3), .rst_cnt(rstc3), .hold_cnt(hold3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    cmds.delete();
    runs.delete();
    zrun     = 0;
    seen     = 1'b0;
    max_cnt  = 0;
    full_rdy = 0;
  endtask

  // Advance one cycle and log the GAP=3 instance's command stream.
  task automatic step3();
    step();
    if (sr3 != 2'b00) begin
      cmds.push_back(int'(sr3));
      if (seen) runs.push_back(zrun);
      zrun = 0;
      seen = 1'b1;
    end else begin
      zrun++;
    end
    if (int'(cnt3) > max_cnt) max_cnt = int'(cnt3);
    if ((cnt3 == 3'd4) && rdy3) full_rdy++;
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; b0 = 1'b0; v3 = 1'b0; b3 = 1'b0;
    mon_clear();
    repeat (3) step();

    // Reset state
    check("rst_sr", 32'(sr0), 32'd0);
    check("rst_q", 32'(q0), 32'd0);
    check("rst_ready", 32'(rdy0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd1);
    check("rst_count", 32'(cnt0), 32'd0);

    // Release: one INIT 01, then idle 00
    rst_n = 1'b1;
    step();
    check("init_sr0", 32'(sr0), 32'd1);
    check("init_sr3", 32'(sr3), 32'd1);
    step();
    check("post_init_sr", 32'(sr0), 32'd0);
    check("post_init_ready", 32'(rdy0), 32'd1);
    check("post_init_busy", 32'(busy0), 32'd0);
    check("post_init_q", 32'(q0), 32'd0);
    repeat (4) step();
    check("idle_sr", 32'(sr0), 32'd0);
    check("idle_busy3", 32'(busy3), 32'd0);

    // GAP=0 back-to-back 1,1,0,0,1 -> 10,00,01,00,10
    vv = 8'b0001_0011;
    for (int i = 0; i < 6; i++) begin
      v0 = (i < 5);
      b0 = (i < 5) ? vv[i] : 1'b0;
      step();
      if (i >= 1) begin
        check($sformatf("g0_sr%0d", i - 1), 32'(sr0), (i == 1 || i == 5) ? 32'd2 :
              (i == 3) ? 32'd1 : 32'd0);
        check($sformatf("g0_q%0d", i - 1), 32'(q0), 32'(vv[i - 1]));
        check($sformatf("g0_cnt%0d", i - 1), 32'(cnt0), (i == 5) ? 32'd0 : 32'd1);
      end
    end
    v0 = 1'b0;
    repeat (3) step();
    check("g0_drain_sr", 32'(sr0), 32'd0);
    check("g0_drain_busy", 32'(busy0), 32'd0);
`ifdef SR_CMD_STATS_EN
    check("stat_set", 32'(set0), 32'd2);
    check("stat_rst", 32'(rstc0), 32'd1);
    check("stat_hold", 32'(hold0), 32'd2);
`endif

    // GAP=3 with source holding valid, alternating 1,0,...
    mon_clear();
    sent = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      v3  = (sent < 8);
      b3  = ((sent % 2) == 0);
      acc = v3 && rdy3;
      step3();
      if (acc) sent++;
    end
    v3 = 1'b0;
    check("g3_accepted", 32'(sent), 32'd8);
    check("g3_ncmds", 32'(cmds.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("g3_cmd%0d", i), (i < cmds.size()) ? 32'(cmds[i]) : 32'hFF,
            ((i % 2) == 0) ? 32'd2 : 32'd1);
    for (int i = 0; i < 7; i++)
      check($sformatf("g3_gap%0d", i), (i < runs.size()) ? 32'(runs[i]) : 32'hFF, 32'd3);
    check("g3_max_count", 32'(max_cnt), 32'd4);
    check("g3_full_ready", 32'(full_rdy), 32'd0);

    // Push and pop together at count 2, pointer wrap, order 1,0,1,0,1,0
    mon_clear();
    vv = 8'b1110_0111;
    bb = 8'b0100_0101;
    for (int e = 0; e < 8; e++) begin
      v3 = vv[e];
      b3 = bb[e];
      step3();
      if (e == 4) check("pp_cnt_before", 32'(cnt3), 32'd2);
      if (e == 5) begin
        check("pp_cnt_after", 32'(cnt3), 32'd2);
        check("pp_sr", 32'(sr3), 32'd1);
      end
    end
    v3 = 1'b0;
    repeat (40) step3();
    check("wrap_ncmds", 32'(cmds.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("wrap_cmd%0d", i), (i < cmds.size()) ? 32'(cmds[i]) : 32'hFF,
            ((i % 2) == 0) ? 32'd2 : 32'd1);
    for (int i = 0; i < 5; i++)
      check($sformatf("wrap_gap%0d", i), (i < runs.size()) ? 32'(runs[i]) : 32'hFF, 32'd3);

    // Asynchronous reset with 3 bits queued
    vv = 8'b0001_1111;
    for (int e = 0; e < 6; e++) begin
      v3 = vv[e];
      b3 = ((e % 2) == 0);
      step();
    end
    v3 = 1'b0;
    check("mid_cnt", 32'(cnt3), 32'd3);
    check("mid_sr", 32'(sr3), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_sr", 32'(sr3), 32'd0);
    check("async_cnt", 32'(cnt3), 32'd0);
    check("async_ready", 32'(rdy3), 32'd0);
    check("async_busy", 32'(busy3), 32'd1);
    check("async_q", 32'(q3), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rerst_sr3", 32'(sr3), 32'd1);
    check("rerst_ready3", 32'(rdy3), 32'd1);
    check("rerst_busy3_gap", 32'(busy3), 32'd1);
    check("rerst_busy0", 32'(busy0), 32'd0);
    mon_clear();
    repeat (30) step3();
    check("rerst_no_old", 32'(cmds.size()), 32'd0);
    check("rerst_cnt", 32'(cnt3), 32'd0);
    check("rerst_busy3_idle", 32'(busy3), 32'd0);
`ifdef SR_CMD_STATS_EN
    check("stat3_rst_init", 32'(rstc3), 32'd0);
    check("stat3_hold_gap", 32'(hold3), 32'd0);
`endif

    // Random stream on GAP=0: never 11, q_model ends at last accepted bit
    bad11    = 0;
    last_bit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      v0 = 1'($urandom_range(0, 1));
      b0 = 1'($urandom_range(0, 1));
      if (v0 && rdy0) last_bit = b0;
      step();
      if (sr0 == 2'b11) bad11++;
    end
    v0 = 1'b0;
    repeat (4) step();
    check("rand_never11", 32'(bad11), 32'd0);
    check("rand_final_q", 32'(q0), 32'(last_bit));
    check("rand_idle", 32'(busy0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
